// File: rtl/cdm_err_pkg.sv
// cdm_err_pkg
// Shared types and constants for the carry-disregard multiplier error monitor.
//   state_t      : window controller states
//   PROD_W/OP_W  : product and operand widths of the multiplier under test
//   HIST_BINS    : number of error-distance histogram bins (optional feature,
//                  enabled with CDM_ERR_HIST_EN)
//   CNT_W_DEF    : default width of window length and counters
//   abs_diff()   : unsigned absolute difference of two products
package cdm_err_pkg;

   localparam int PROD_W    = 32;
   localparam int OP_W      = 16;
   localparam int HIST_BINS = 33;
   localparam int BIN_W     = 6;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/cdm_err_msb.sv
// cdm_err_msb
// Combinational leading-one encoder used to pick the histogram bin of an
// error distance. Only instantiated when CDM_ERR_HIST_EN is defined.
//   i_ed  : 32-bit error distance
//   o_bin : 0 when i_ed == 0, otherwise (index of most significant one) + 1
module cdm_err_msb
   import cdm_err_pkg::*;
(
   input  logic [PROD_W-1:0] i_ed,
   output logic [BIN_W-1:0]  o_bin
);

   // Ascending scan: the highest set bit is the last one to write o_bin.
   always_comb begin
      o_bin = '0;
      for (int i = 0; i < PROD_W; i++) begin
         if (i_ed[i]) o_bin = BIN_W'(i + 1);
      end
   end

endmodule

// File: rtl/cdm16_err_monitor.sv
// cdm16_err_monitor
// Streaming error-statistics stage for the 16x16 carry-disregard approximate
// multiplier. Each accepted sample (a, b, r_approx) is compared against the
// exact product; error count, sum and maximum of error distance are
// accumulated over a window of i_win_len samples.
// Optional ED histogram: define CDM_ERR_HIST_EN.
//
// Ports
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start, i_win_len  : open a window (IDLE/DONE only), window length
//   i_in_valid/o_in_ready, i_a, i_b, i_r_approx : sample stream
//   o_busy, o_done      : window in progress / window complete
//   o_sample_cnt, o_err_cnt, o_sum_ed, o_max_ed : live statistics
//   i_hist_sel, o_hist_cnt : histogram bin read (0 when feature disabled)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until win_len have been taken
// DRAIN | no more accepts, waiting for the two pipeline stages to empty
// DONE  | statistics frozen until the next start
module cdm16_err_monitor
   import cdm_err_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [CNT_W-1:0]        i_win_len,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [OP_W-1:0]         i_a,
   input  logic [OP_W-1:0]         i_b,
   input  logic [PROD_W-1:0]       i_r_approx,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [CNT_W-1:0]        o_sample_cnt,
   output logic [CNT_W-1:0]        o_err_cnt,
   output logic [PROD_W+CNT_W-1:0] o_sum_ed,
   output logic [PROD_W-1:0]       o_max_ed,
   input  logic [BIN_W-1:0]        i_hist_sel,
   output logic [CNT_W-1:0]        o_hist_cnt
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_start_ok;
   logic                    w_in_ready;
   logic                    w_busy;
   logic                    w_done;
   logic                    w_accept;

   logic [CNT_W-1:0]        r_remain;

   logic                    r_s1_vld;
   logic [OP_W-1:0]         r_s1_a;
   logic [OP_W-1:0]         r_s1_b;
   logic [PROD_W-1:0]       r_s1_r;
   logic [PROD_W-1:0]       w_exact;

   logic                    r_s2_vld;
   logic [PROD_W-1:0]       r_s2_ed;

   logic [CNT_W-1:0]        r_sample_cnt;
   logic [CNT_W-1:0]        r_err_cnt;
   logic [PROD_W+CNT_W-1:0] r_sum_ed;
   logic [PROD_W-1:0]       r_max_ed;

   assign w_accept = i_in_valid & w_in_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_in_ready  = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_done = (r_state == DONE);
            if (i_start) begin
               w_start_ok  = 1'b1;
               w_state_nxt = (i_win_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            w_busy     = 1'b1;
            w_in_ready = (r_remain != '0);
            // Last sample of the window is being taken this cycle.
            if (i_in_valid && w_in_ready && (r_remain == CNT_W'(1)))
               w_state_nxt = DRAIN;
         end
         DRAIN: begin
            w_busy = 1'b1;
            if (!r_s1_vld && !r_s2_vld) w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Samples still to accept in the current window (terminal count at 0).
   always_ff @(posedge i_clk) begin
      if (i_rst)           r_remain <= '0;
      else if (w_start_ok) r_remain <= i_win_len;
      else if (w_accept)   r_remain <= r_remain - CNT_W'(1);
   end

   assign w_exact = {{(PROD_W-OP_W){1'b0}}, r_s1_a} * {{(PROD_W-OP_W){1'b0}}, r_s1_b};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_r   <= '0;
         r_s2_vld <= 1'b0;
         r_s2_ed  <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_a <= i_a;
            r_s1_b <= i_b;
            r_s1_r <= i_r_approx;
         end
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) r_s2_ed <= abs_diff(w_exact, r_s1_r);
      end
   end

   // A start is only honoured in IDLE/DONE where the pipeline is empty, so
   // clearing here never races an accumulator update.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_ok) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_sum_ed     <= '0;
         r_max_ed     <= '0;
      end else if (r_s2_vld) begin
         r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         r_err_cnt    <= r_err_cnt + CNT_W'(r_s2_ed != '0);
         r_sum_ed     <= r_sum_ed + (PROD_W+CNT_W)'(r_s2_ed);
         if (r_s2_ed > r_max_ed) r_max_ed <= r_s2_ed;
      end
   end

`ifdef CDM_ERR_HIST_EN
   logic [BIN_W-1:0] w_bin;
   logic [CNT_W-1:0] r_hist [HIST_BINS];

   cdm_err_msb u_msb (
      .i_ed  (r_s2_ed),
      .o_bin (w_bin)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_ok) begin
         for (int k = 0; k < HIST_BINS; k++) r_hist[k] <= '0;
      end else if (r_s2_vld) begin
         r_hist[w_bin] <= r_hist[w_bin] + CNT_W'(1);
      end
   end

   assign o_hist_cnt = (i_hist_sel < BIN_W'(HIST_BINS)) ? r_hist[i_hist_sel] : '0;
`else
   logic w_unused_hist_sel;
   assign w_unused_hist_sel = ^i_hist_sel;
   assign o_hist_cnt        = '0;
`endif

   assign o_in_ready   = w_in_ready;
   assign o_busy       = w_busy;
   assign o_done       = w_done;
   assign o_sample_cnt = r_sample_cnt;
   assign o_err_cnt    = r_err_cnt;
   assign o_sum_ed     = r_sum_ed;
   assign o_max_ed     = r_max_ed;

endmodule

// File: tb/tb_cdm16_err_monitor.sv
// tb_cdm16_err_monitor
// Directed + randomized bench for cdm16_err_monitor. Expected statistics are
// computed from the list of error distances of the samples handed over.
module tb_cdm16_err_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] win_len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] r_approx;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;
   logic [15:0] err_cnt;
   logic [47:0] sum_ed;
   logic [31:0] max_ed;
   logic [5:0]  hist_sel;
   logic [15:0] hist_cnt;

   int n_run  = 0;
   int n_fail = 0;

   longint unsigned ed_q[$];
   bit              vq[$];
   logic [15:0]     da[$];
   logic [15:0]     db[$];
   logic [31:0]     dr[$];

   always #5 clk = ~clk;

   cdm16_err_monitor dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_win_len    (win_len),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .i_a          (a),
      .i_b          (b),
      .i_r_approx   (r_approx),
      .o_busy       (busy),
      .o_done       (done),
      .o_sample_cnt (sample_cnt),
      .o_err_cnt    (err_cnt),
      .o_sum_ed     (sum_ed),
      .o_max_ed     (max_ed),
      .i_hist_sel   (hist_sel),
      .o_hist_cnt   (hist_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned ref_ed(input logic [15:0] x, input logic [15:0] y,
                                              input logic [31:0] rr);
      longint unsigned ex;
      longint unsigned ap;
      ex = x;
      ex = ex * y;
      ap = rr;
      return (ex > ap) ? (ex - ap) : (ap - ex);
   endfunction

   function automatic int bin_of(input longint unsigned e);
      int k = 0;
      while (e != 0) begin
         k++;
         e = e >> 1;
      end
      return k;
   endfunction

   task automatic drive_sample(input bit use_dir);
      logic [31:0] ex;
      if (use_dir && da.size() > 0) begin
         a        = da.pop_front();
         b        = db.pop_front();
         r_approx = dr.pop_front();
      end else begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         ex = {16'h0, a} * {16'h0, b};
         case ($urandom_range(2))
            0:       r_approx = ex;
            1:       r_approx = ex ^ ($urandom >> $urandom_range(31));
            default: r_approx = $urandom;
         endcase
      end
   endtask

   // Statistics must match the ED list; call only while stats are frozen.
   task automatic check_stats(input string tag);
      longint unsigned s = 0;
      longint unsigned m = 0;
      int              e = 0;
      foreach (ed_q[i]) begin
         s += ed_q[i];
         if (ed_q[i] > m) m = ed_q[i];
         if (ed_q[i] != 0) e++;
      end
      chk({tag, ".sample_cnt"}, sample_cnt, ed_q.size());
      chk({tag, ".err_cnt"},    err_cnt,    e);
      chk({tag, ".sum_ed"},     sum_ed,     s);
      chk({tag, ".max_ed"},     max_ed,     m);
`ifdef CDM_ERR_HIST_EN
      for (int k = 0; k <= 33; k++) begin
         int c = 0;
         foreach (ed_q[i]) if (bin_of(ed_q[i]) == k) c++;
         hist_sel = (k == 33) ? 6'd40 : 6'(k);
         #0.1;
         chk({tag, ".hist"}, hist_cnt, (k == 33) ? 0 : c);
      end
`else
      hist_sel = 6'($urandom_range(63));
      #1;
      chk({tag, ".hist_off"}, hist_cnt, 0);
`endif
   endtask

   task automatic run_window(input int wl, input int vpct, input bit poke, input string tag);
      int acc = 0;
      int cyc = 0;
      ed_q.delete();
      in_valid = 1'b0;
      start    = 1'b1;
      win_len  = 16'(wl);
      @(posedge clk); #1;
      start = 1'b0;
      while (acc < wl && cyc < 4000) begin
         bit v;
         if (vq.size() > 0) v = vq.pop_front();
         else               v = ($urandom_range(99) < vpct);
         drive_sample(v);
         in_valid = v;
         if (poke && cyc == 2) begin
            start   = 1'b1;
            win_len = 16'(wl + 3);
         end
         chk({tag, ".in_ready"}, in_ready, 1);
         chk({tag, ".busy_run"}, busy, 1);
         chk({tag, ".done_run"}, done, 0);
         if (v) begin
            ed_q.push_back(ref_ed(a, b, r_approx));
            acc++;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      chk({tag, ".accepts"}, acc, wl);
      // Keep offering samples after the window is full; none may be taken.
      in_valid = 1'b1;
      drive_sample(1'b0);
      for (int k = 1; k <= 3; k++) begin
         chk({tag, ".in_ready_full"}, in_ready, 0);
         @(posedge clk); #1;
         chk({tag, ".done_lat"}, done, (k == 3));
         chk({tag, ".busy_drain"}, busy, (k < 3));
         if (k == 1) chk({tag, ".live_cnt1"}, sample_cnt, wl - 1);
         if (k == 2) chk({tag, ".live_cnt2"}, sample_cnt, wl);
      end
      in_valid = 1'b0;
      check_stats(tag);
      repeat (2) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         drive_sample(1'b0);
      end
      chk({tag, ".done_hold"}, done, 1);
      check_stats({tag, ".hold"});
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      win_len  = '0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      r_approx = '0;
      hist_sel = '0;
      ed_q.delete();

      repeat (2) @(posedge clk);
      #1;
      chk("rst.in_ready", in_ready, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      check_stats("rst");
      rst = 1'b0;
      @(posedge clk); #1;

      da.push_back(16'hFFFF); db.push_back(16'hFFFF); dr.push_back(32'hFFFE0001);
      run_window(1, 100, 1'b0, "exact");
      chk("exact.cnt", sample_cnt, 1);
      chk("exact.err", err_cnt, 0);
      chk("exact.sum", sum_ed, 0);
      chk("exact.max", max_ed, 0);

      da.push_back(16'd3);    db.push_back(16'd7);    dr.push_back(32'd26);
      da.push_back(16'h1234); db.push_back(16'h0010); dr.push_back(32'h0001_2240);
      da.push_back(16'hFFFF); db.push_back(16'd2);    dr.push_back(32'h0001_FFFE);
      run_window(3, 100, 1'b0, "mixed");
      chk("mixed.err", err_cnt, 2);
      chk("mixed.sum", sum_ed, 48'h105);
      chk("mixed.max", max_ed, 32'h100);

      vq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      run_window(4, 100, 1'b0, "bp");
      chk("bp.cnt", sample_cnt, 4);
      vq.delete();

      ed_q.delete();
      in_valid = 1'b1;
      drive_sample(1'b0);
      start   = 1'b1;
      win_len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero.done", done, 1);
      chk("zero.busy", busy, 0);
      repeat (3) begin
         chk("zero.in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("zero.done_hold", done, 1);
      end
      in_valid = 1'b0;
      check_stats("zero");

      run_window(8, 100, 1'b1, "start_ignored");

      ed_q.delete();
      start   = 1'b1;
      win_len = 16'd10;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      repeat (5) begin
         drive_sample(1'b0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid.busy", busy, 0);
      chk("rst_mid.done", done, 0);
      chk("rst_mid.in_ready", in_ready, 0);
      check_stats("rst_mid");
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("rst_mid.idle", busy, 0);
      check_stats("rst_mid.flushed");
      run_window(6, 100, 1'b0, "post_rst");

      for (int i = 0; i < 8; i++) begin
         run_window($urandom_range(25, 1), $urandom_range(100, 40), 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
